// File: rtl/regfile_sequencer.sv
// Four-state instruction sequencer for an external 8-entry register file.
// It accepts one instruction, reads two operands, executes, and writes back.
module regfile_sequencer #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [15:0]  instr,
   input  logic         instr_valid,
   output logic         instr_ready,
   output logic [2:0]   rf_sel_A,
   output logic [2:0]   rf_sel_B,
   input  logic [N-1:0] rf_out_A,
   input  logic [N-1:0] rf_out_B,
   output logic [2:0]   rf_wr_addr,
   output logic         rf_wr_en,
   output logic [N-1:0] rf_wr_data,
   output logic         done,
   output logic         illegal,
   output logic         zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_MOV  = 4'd7;
   localparam logic [3:0] OP_LDI  = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;

   state_t       state_reg;
   state_t       state_next;

   logic [15:0]  instr_reg;
   logic [N-1:0] op_a_reg;
   logic [N-1:0] op_b_reg;
   logic [N-1:0] result_reg;
   logic [2:0]   wr_addr_reg;
   logic         wr_en_reg;
   logic         done_reg;
   logic         illegal_reg;
   logic         zero_reg;

   logic [3:0]   opcode;
   logic [2:0]   rd_field;
   logic [2:0]   rs_field;
   logic [2:0]   rt_field;
   logic [N-1:0] imm6_sext;
   logic [N-1:0] imm9_zext;
   logic [N-1:0] alu_result;
   logic         alu_writes;
   logic         alu_illegal;
   logic         handshake;

   assign opcode    = instr_reg[15:12];
   assign rd_field  = instr_reg[11:9];
   assign rs_field  = instr_reg[8:6];
   assign rt_field  = instr_reg[5:3];
   assign imm6_sext = {{(N-6){instr_reg[5]}}, instr_reg[5:0]};
   assign imm9_zext = {{(N-9){1'b0}}, instr_reg[8:0]};

   assign instr_ready = (state_reg == IDLE);
   assign handshake   = instr_ready && instr_valid;

   // Read selects only carry the operand fields while the operands are in flight.
   assign rf_sel_A = (state_reg == READ || state_reg == EXEC) ? rs_field : 3'd0;
   assign rf_sel_B = (state_reg == READ || state_reg == EXEC) ? rt_field : 3'd0;

   assign rf_wr_addr = wr_addr_reg;
   assign rf_wr_en   = wr_en_reg;
   assign rf_wr_data = result_reg;
   assign done       = done_reg;
   assign illegal    = illegal_reg;
   assign zero       = zero_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (instr_valid) state_next = READ;
         READ:    state_next = EXEC;
         EXEC:    state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      alu_result  = '0;
      alu_writes  = 1'b1;
      alu_illegal = 1'b0;
      case (opcode)
         OP_NOP:  alu_writes = 1'b0;
         OP_ADD:  alu_result = op_a_reg + op_b_reg;
         OP_SUB:  alu_result = op_a_reg - op_b_reg;
         OP_AND:  alu_result = op_a_reg & op_b_reg;
         OP_OR:   alu_result = op_a_reg | op_b_reg;
         OP_XOR:  alu_result = op_a_reg ^ op_b_reg;
         OP_ADDI: alu_result = op_a_reg + imm6_sext;
         OP_MOV:  alu_result = op_a_reg;
         OP_LDI:  alu_result = imm9_zext;
         OP_SHL:  alu_result = {op_a_reg[N-2:0], 1'b0};
         OP_SHR:  alu_result = {1'b0, op_a_reg[N-1:1]};
         default: begin
            alu_writes  = 1'b0;
            alu_illegal = 1'b1;
         end
      endcase
   end

   // Writeback outputs are loaded on entry to WB and cleared on exit, so
   // they are register-driven and only ever high for that single cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_reg   <= '0;
         op_a_reg    <= '0;
         op_b_reg    <= '0;
         result_reg  <= '0;
         wr_addr_reg <= '0;
         wr_en_reg   <= 1'b0;
         done_reg    <= 1'b0;
         illegal_reg <= 1'b0;
         zero_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (handshake) instr_reg <= instr;
            end
            READ: begin
               op_a_reg <= rf_out_A;
               op_b_reg <= rf_out_B;
            end
            EXEC: begin
               result_reg  <= alu_result;
               wr_addr_reg <= rd_field;
               wr_en_reg   <= alu_writes;
               done_reg    <= 1'b1;
               illegal_reg <= alu_illegal;
               if (alu_writes) zero_reg <= (alu_result == '0);
            end
            WB: begin
               result_reg  <= '0;
               wr_addr_reg <= '0;
               wr_en_reg   <= 1'b0;
               done_reg    <= 1'b0;
               illegal_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: an 8-entry register file around the DUT,
// a per-instruction behavioural model, and a cycle-by-cycle output compare.
module tb_regfile_sequencer;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [15:0]  instr = '0;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   logic [2:0]   rf_sel_A, rf_sel_B, rf_wr_addr;
   logic [N-1:0] rf_out_A, rf_out_B, rf_wr_data;
   logic         rf_wr_en, done, illegal, zero;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_sequencer #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .rf_sel_A(rf_sel_A), .rf_sel_B(rf_sel_B),
      .rf_out_A(rf_out_A), .rf_out_B(rf_out_B), .rf_wr_addr(rf_wr_addr),
      .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data), .done(done),
      .illegal(illegal), .zero(zero)
   );

   always #5 clk = ~clk;

   // Environment register file, written only by the DUT (and preloads).
   logic [N-1:0] rf [8];
   assign rf_out_A = rf[rf_sel_A];
   assign rf_out_B = rf[rf_sel_B];
   always @(posedge clk) if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_phase = -1 idle, otherwise edges since the handshake (0 READ, 1 EXEC, 2 WB).
   int           m_phase = -1;
   logic [15:0]  m_instr = '0;
   logic [N-1:0] m_rf [8];
   logic [N-1:0] m_res = '0;
   logic         m_wr = 1'b0;
   logic         m_ill = 1'b0;
   logic         m_zero = 1'b0;

   task automatic model_exec(input logic [15:0] w);
      int a, b, imm, r;
      int op;
      op  = int'(w[15:12]);
      a   = int'(m_rf[w[8:6]]);
      b   = int'(m_rf[w[5:3]]);
      imm = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
      r   = 0;
      case (op)
         1:  r = a + b;
         2:  r = a - b;
         3:  r = a & b;
         4:  r = a | b;
         5:  r = a ^ b;
         6:  r = a + imm;
         7:  r = a;
         8:  r = int'(w[8:0]);
         9:  r = a * 2;
         10: r = a / 2;
         default: r = 0;
      endcase
      m_res = r[N-1:0];
      m_wr  = (op >= 1 && op <= 10);
      m_ill = (op >= 11);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = -1;
         m_zero  = 1'b0;
      end else if (m_phase == 2) begin
         if (m_wr) m_rf[m_instr[11:9]] = m_res;
         m_phase = -1;
      end else if (m_phase >= 0) begin
         if (m_phase == 1 && m_wr) m_zero = (m_res == '0);
         m_phase++;
      end else if (instr_valid) begin
         m_instr = instr;
         model_exec(instr);
         m_phase = 0;
      end
   end

   logic in_wb, in_ops;
   always @(negedge clk) begin
      in_wb  = (m_phase == 2);
      in_ops = (m_phase == 0 || m_phase == 1);
      chk("instr_ready", instr_ready, m_phase == -1);
      chk("rf_sel_A", rf_sel_A, in_ops ? m_instr[8:6] : 3'd0);
      chk("rf_sel_B", rf_sel_B, in_ops ? m_instr[5:3] : 3'd0);
      chk("done", done, in_wb);
      chk("illegal", illegal, in_wb && m_ill);
      chk("rf_wr_en", rf_wr_en, in_wb && m_wr);
      chk("rf_wr_addr", rf_wr_addr, in_wb ? m_instr[11:9] : 3'd0);
      if (!in_wb) chk("rf_wr_data_idle", rf_wr_data, '0);
      else if (m_wr) chk("rf_wr_data", rf_wr_data, m_res);
      chk("zero", zero, m_zero);
   end

   task automatic preload(input int idx, input logic [N-1:0] val);
      @(negedge clk);
      rf[idx] <= val;
      m_rf[idx] = val;
   endtask

   task automatic check_rf_state();
      int mism = 0;
      for (int k = 0; k < 8; k++) if (rf[k] !== m_rf[k]) mism++;
      chk("rf_state", mism, 0);
   endtask

   // Issue one instruction and check the WB cycle against hand-computed values.
   task automatic run(input logic [15:0] w, input logic [N-1:0] e_data, input logic e_wr,
                      input logic e_ill, input logic e_zero, input bit release_rst);
      int lat = 0;
      @(negedge clk);
      if (release_rst) rst_n = 1'b1;
      instr = w;
      instr_valid = 1'b1;
      if (release_rst) begin
         #1 chk("ready_after_reset", instr_ready, 1'b1);
      end
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         @(negedge clk);
         if (c == 1) instr_valid = 1'b0;
         if (done) begin
            lat = c;
            if (e_wr) chk("lit_data", rf_wr_data, e_data);
            chk("lit_wr_en", rf_wr_en, e_wr);
            chk("lit_illegal", illegal, e_ill);
            chk("lit_addr", rf_wr_addr, w[11:9]);
            chk("lit_zero", zero, e_zero);
         end
      end
      chk("latency", lat, 3);
      @(negedge clk);
      check_rf_state();
      $display("instr %h: latency %0d wr_en %0b addr %0d data %h illegal %0b zero %0b",
               w, lat, e_wr, w[11:9], e_data, e_ill, e_zero);
   endtask

   int   d1, d2;
   logic [N-1:0] v1, v2;

   initial begin
      #1 rst_n = 1'b0;
      for (int k = 0; k < 8; k++) begin
         rf[k] <= '0;
         m_rf[k] = '0;
      end
      @(negedge clk);
      #1;
      chk("reset_ready", instr_ready, 1'b1);
      chk("reset_done", done, 1'b0);
      chk("reset_wr_en", rf_wr_en, 1'b0);
      chk("reset_zero", zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      preload(1, 16'h0005);
      preload(2, 16'h0003);

      run(16'h1650, 16'h0008, 1, 0, 0, 0);   // ADD r3,r1,r2
      preload(1, 16'h0001);
      run(16'h627F, 16'h0000, 1, 0, 1, 0);   // ADDI r1,r1,-1
      run(16'hF000, 16'h0000, 0, 1, 1, 0);   // illegal, zero held
      run(16'h8BFF, 16'h01FF, 1, 0, 0, 0);   // LDI r5,0x1FF
      run(16'h2D50, 16'h01FC, 1, 0, 0, 0);   // SUB r6,r5,r2
      run(16'h2EA8, 16'hFE04, 1, 0, 0, 0);   // SUB r7,r2,r5 (wraps)
      run(16'h33F0, 16'h0004, 1, 0, 0, 0);   // AND r1,r7,r6
      run(16'h45F0, 16'hFFFC, 1, 0, 0, 0);   // OR r2,r7,r6
      run(16'h5890, 16'h0000, 1, 0, 1, 0);   // XOR r4,r2,r2
      run(16'h0000, 16'h0000, 0, 0, 1, 0);   // NOP, zero held
      run(16'h71C0, 16'hFE04, 1, 0, 0, 0);   // MOV r0,r7
      run(16'h9600, 16'hFC08, 1, 0, 0, 0);   // SHL r3,r0
      run(16'hAA00, 16'h7F02, 1, 0, 0, 0);   // SHR r5,r0
      run(16'h6C5F, 16'h0023, 1, 0, 0, 0);   // ADDI r6,r1,+31
      run(16'hB123, 16'h0000, 0, 1, 0, 0);   // illegal
      run(16'h1E88, 16'h0000, 1, 0, 1, 0);   // ADD r7,r2,r1 carry dropped

      // Reset while in EXEC: everything clears at once and r3 is never written.
      @(negedge clk);
      instr = 16'h1650;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_done", done, 1'b0);
      chk("abort_wr_en", rf_wr_en, 1'b0);
      chk("abort_sel_A", rf_sel_A, 3'd0);
      chk("abort_zero", zero, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_no_write", rf[3], 16'hFC08);
      $display("reset in EXEC: outputs cleared, r3 kept %h", rf[3]);
      run(16'h8405, 16'h0005, 1, 0, 0, 1);   // LDI r2,5 on first edge after release

      // Back-to-back with instr_valid held: second ADD reads the first result.
      d1 = 0; d2 = 0; v1 = '0; v2 = '0;
      @(negedge clk);
      instr = 16'h1650;                      // ADD r3,r1,r2 = 4+5
      instr_valid = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) instr = 16'h18D8;       // ADD r4,r3,r3
         if (c == 5) instr_valid = 1'b0;
         if (done) begin
            if (d1 == 0) begin d1 = c; v1 = rf_wr_data; end
            else if (d2 == 0) begin d2 = c; v2 = rf_wr_data; end
         end
      end
      chk("b2b_done1_cycle", d1, 3);
      chk("b2b_done2_cycle", d2, 7);
      chk("b2b_data1", v1, 16'h0009);
      chk("b2b_data2", v2, 16'h0012);
      check_rf_state();
      $display("back-to-back: done at %0d and %0d, data %h then %h", d1, d2, v1, v2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, giving the register data width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr  input  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [5:0] imm6, [8:0] imm9.
REQ-005 SHALL have port instr_valid  input  1  instr is presented.
REQ-006 SHALL have port instr_ready  output  1  sequencer accepts instr this cycle.
REQ-007 SHALL have port rf_sel_A  output  3  register-file read select A.
REQ-008 SHALL have port rf_sel_B  output  3  register-file read select B.
REQ-009 SHALL have port rf_out_A  input  N  register-file read data A, combinational from rf_sel_A.
REQ-010 SHALL have port rf_out_B  input  N  register-file read data B, combinational from rf_sel_B.
REQ-011 SHALL have port rf_wr_addr  output  3  register-file write address.
REQ-012 SHALL have port rf_wr_en  output  1  register-file write enable; the write takes effect on the rising edge that ends the cycle.
REQ-013 SHALL have port rf_wr_data  output  N  register-file write data.
REQ-014 SHALL have port done  output  1  one-cycle pulse when an instruction retires.
REQ-015 SHALL have port illegal  output  1  one-cycle pulse, coincident with done, for an undefined opcode.
REQ-016 SHALL have port zero  output  1  set when the last computed result is zero; held until the next retire.

Function
REQ-017 SHALL implement the FSM IDLE -> READ -> EXEC -> WB -> IDLE, one cycle per state except IDLE.
REQ-018 SHALL drive instr_ready=1 only in IDLE; a handshake is valid&ready at a rising edge; the instr word SHALL then be latched and the FSM SHALL enter READ.
REQ-019 SHALL, in IDLE with instr_valid=0, remain in IDLE with no outputs changing.
REQ-020 SHALL drive rf_sel_A=rs and rf_sel_B=rt from the latched instr in READ and EXEC; in IDLE and WB they SHALL be 0.
REQ-021 SHALL capture rf_out_A and rf_out_B into operand registers at the edge leaving READ.
REQ-022 SHALL compute the result at the edge leaving EXEC into an N-bit register, with arithmetic modulo 2^N (carries discarded):
  - 0 NOP
  - 1 ADD A+B
  - 2 SUB A-B
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI A+sign-extend(imm6)
  - 7 MOV A
  - 8 LDI zero-extend(imm9)
  - 9 SHL A<<1
  - 10 SHR A>>1 (logical)
  - 11-15 illegal.
REQ-023 SHALL, in WB, assert done=1, drive rf_wr_addr=rd and rf_wr_data=result, and set rf_wr_en=1 for opcodes 1-10 and 0 for NOP or illegal.
REQ-024 SHALL assert illegal=1 in WB for opcodes 11-15.
REQ-025 SHALL drive rf_wr_en, rf_wr_addr, rf_wr_data, done and illegal from registers (glitch-free); they SHALL be 0 outside WB.
REQ-026 SHALL give a latency of exactly 3 edges from the handshake edge E0: READ after E0, EXEC after E1, WB after E2, with the register file written at E3.
REQ-027 SHALL give a maximum throughput of one instruction per 4 cycles; the earliest next handshake is at E4.
REQ-028 SHALL update zero at the edge leaving EXEC for opcodes 1-10; zero SHALL be unchanged by NOP and illegal opcodes.
REQ-029 SHALL ignore instr and instr_valid changes outside IDLE; the latched copy governs the instruction.
REQ-030 SHALL allow rd to equal rs or rt; operands are captured before the write, so old values are used.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-instruction, immediately force the FSM to IDLE.
REQ-032 SHALL, on reset, clear all outputs and internal registers to 0, except instr_ready, which SHALL be 1 once in IDLE.
REQ-033 SHALL issue no register-file write for an instruction aborted by reset.
REQ-034 SHALL act on instr_valid at the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL cover ADD: RF r1=0x0005, r2=0x0003; instr 0x1650 (ADD r3,r1,r2) handshaken at E0 -> at E2+ rf_wr_en=1, rf_wr_addr=3, rf_wr_data=0x0008, done=1, zero=0.
REQ-036 SHALL cover ADDI with a negative immediate: r1=0x0001; instr 0x627F (ADDI r1,r1,-1) -> rf_wr_data=0x0000, zero=1.
REQ-037 SHALL cover LDI: instr 0x8BFF (LDI r5,0x1FF) -> rf_wr_addr=5, rf_wr_data=0x01FF.
REQ-038 SHALL cover an illegal opcode: instr 0xF000 -> in WB done=1, illegal=1, rf_wr_en=0, zero unchanged.
REQ-039 SHALL cover reset mid-operation: rst_n pulsed low while in EXEC -> outputs 0 immediately, no write, instr_ready=1 after release.
REQ-040 SHALL cover back-to-back operation: instr_valid held high with two instructions -> handshakes at E0 and E4, two done pulses 4 cycles apart, second uses the first's written value.
